pipe_stage_buf: RTL and testbench

//  Parametrised inter-stage pipeline buffer; successor to the fixed per-stage register blocks (mm2->wb etc.).

---
 rtl/pipe_stage_buf_pkg.sv | 34 +++
 rtl/pipe_stage_buf_sat_counter.sv | 38 +++
 rtl/pipe_stage_buf.sv | 131 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline buffers.
//  - buf_state_e : occupancy encoding of a pipe_stage_buf (EMPTY / ONE / TWO)
//  - mm2_wb_t    : stage bundle carried from MM2 to WB. The producer packs it,
//                  the consumer unpacks it, and the buffer treats it as opaque bits.
//  - occupied()  : true when a buffer state holds at least one entry
package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } buf_state_e;

  // MM2 -> WB bundle; field order fixes the bit offsets (ertn at bit 0).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
    logic [31:0] csr_wdata;
    logic [13:0] csr_addr;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic        rf_we;
    logic        excp;
    logic        ertn;
  } mm2_wb_t;

  localparam int MM2_WB_W = $bits(mm2_wb_t);

  function automatic logic occupied(input buf_state_e s);
    return s != ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating event counter. Performance counters reuse it.
//  clk, rst_n : clock and asynchronous active-low reset (count resets to 0)
//  inc        : add one this cycle; the count holds once it reaches all-ones
//  clr        : synchronous clear to 0; takes priority over inc
//  cnt        : current count, CNT_W bits
module pipe_stage_buf_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default on its first line. That
  // keeps each path assigned, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together, and the order of assignments has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer carrying an opaque payload over valid/ready.
//  clk, rst_n          : clock and asynchronous active-low reset
//  flush               : synchronous kill of all held and incoming entries
//  in_valid/in_ready   : producer handshake; in_data is sampled only on acceptance
//  in_data             : producer payload, WIDTH bits
//  out_valid/out_ready : consumer handshake; out_data comes from the main register
//  out_data            : payload to consumer, WIDTH bits
//  cnt_clr             : synchronous clear of stall_cnt
//  stall_cnt           : saturating count of cycles with out_valid & !out_ready
// SKID=1 adds a second entry, and in_ready then depends only on flops.
// SKID=0 keeps a single entry, and in_ready follows out_ready combinationally.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH     = MM2_WB_W,
  parameter bit SKID      = 1'b1,
  parameter bit CLR_FLUSH = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             acc_in, acc_out;
  logic             stall_inc;

  assign out_valid = occupied(state_q);
  assign out_data  = main_q;
  assign acc_in    = in_valid & in_ready;
  assign acc_out   = out_valid & out_ready;

  // Flush does not gate in_ready. A beat accepted during a flush is dropped.
  if (SKID) begin : g_ready_reg
    assign in_ready = (state_q != ST_TWO);
  end else begin : g_ready_comb
    assign in_ready = !out_valid | out_ready;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc_in) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (acc_in && acc_out) begin
          main_d = in_data;
        end else if (acc_out) begin
          state_d = ST_EMPTY;
        end else if (acc_in && SKID) begin
          state_d = ST_TWO;
          skid_d  = in_data;
        end
      end
      ST_TWO: begin
        // The skid entry moves up into main. The skid never drives the output directly.
        if (out_ready) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush overrides every transition above, including the load of an accepted beat.
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLR_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end
  end

  // NOTE: payload registers are reset explicitly. out_data must then read 0,
  // not X, after reset. Without that, the reset could be dropped from a
  // datapath register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  if (SKID) begin : g_skid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) skid_q <= '0;
      else        skid_q <= skid_d;
    end
  end else begin : g_no_skid
    logic skid_unused;
    assign skid_q      = '0;
    assign skid_unused = ^skid_d;
  end

  assign stall_inc = out_valid & ~out_ready;

  pipe_stage_buf_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_inc),
    .clr  (cnt_clr),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf. It uses three instances:
//  dut  : SKID=1, CLR_FLUSH=1, CNT_W=16 (main instance)
//  dut4 : the same inputs as dut, with CNT_W=4, to show counter saturation
//  dut0 : SKID=0 single-entry variant with its own inputs
module tb_pipe_stage_buf;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush, in_valid, out_ready, cnt_clr;
  logic [W-1:0] in_data;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [15:0]  stall_cnt;

  logic         c4_in_ready, c4_out_valid;
  logic [W-1:0] c4_out_data;
  logic [3:0]   c4_stall_cnt;

  logic         s0_flush, s0_in_valid, s0_out_ready, s0_cnt_clr;
  logic [W-1:0] s0_in_data;
  logic         s0_in_ready, s0_out_valid;
  logic [W-1:0] s0_out_data;
  logic [15:0]  s0_stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(W), .SKID(1'b1), .CLR_FLUSH(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  pipe_stage_buf #(.WIDTH(W), .SKID(1'b1), .CLR_FLUSH(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c4_in_ready), .in_data(in_data),
    .out_valid(c4_out_valid), .out_ready(out_ready), .out_data(c4_out_data),
    .cnt_clr(cnt_clr), .stall_cnt(c4_stall_cnt)
  );

  pipe_stage_buf #(.WIDTH(W), .SKID(1'b0), .CLR_FLUSH(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .cnt_clr(s0_cnt_clr), .stall_cnt(s0_stall_cnt)
  );

  // Advance one edge and settle, so that outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
    // Put one entry in main, then stall for one cycle.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_A5A5;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_data !== 32'hA5A5_A5A5) begin failures++; $display("FAIL pre_rst_data got=%h exp=a5a5a5a5", out_data); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL pre_rst_stall got=%0d exp=1", stall_cnt); end
    // Assert reset asynchronously between clock edges.
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL async_rst_stall got=%0d exp=0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL async_rst_in_ready got=%0h exp=1", in_ready); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL async_rst_data got=%h exp=0", out_data); end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== i) begin failures++; $display("FAIL stream_beat%0d got v=%0h d=%0h exp v=1 d=%0h", i, out_valid, out_data, i); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready%0d got=%0h exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd5;
    tick();
    checks++; if (out_data !== 32'd5 || in_ready !== 1'b1) begin failures++; $display("FAIL skid_one got d=%0h r=%0h exp d=5 r=1", out_data, in_ready); end
    in_data = 32'd6;
    tick();
    checks++; if (out_data !== 32'd5 || in_ready !== 1'b0) begin failures++; $display("FAIL skid_two got d=%0h r=%0h exp d=5 r=0", out_data, in_ready); end
    in_data = 32'd7;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd5 || in_ready !== 1'b0) begin failures++; $display("FAIL skid_hold got v=%0h d=%0h r=%0h exp v=1 d=5 r=0", out_valid, out_data, in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 32'd6 || in_ready !== 1'b1) begin failures++; $display("FAIL skid_rel6 got d=%0h r=%0h exp d=6 r=1", out_data, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'd7) begin failures++; $display("FAIL skid_rel7 got v=%0h d=%0h exp v=1 d=7", out_valid, out_data); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_empty got=%0h exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1;
    tick();
    in_data = 32'd2;
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_two got=%0h exp=0", in_ready); end
    in_data = 32'd9; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL flush_clear got v=%0h d=%0h exp v=0 d=0", out_valid, out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0h exp=1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || out_data === 32'd9) begin failures++; $display("FAIL flush_no9_%0d got v=%0h d=%0h exp v=0 d!=9", i, out_valid, out_data); end
    end
  endtask

  task automatic test_counter();
    out_ready = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; in_valid = 1'b1; in_data = 32'd3;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    checks++; if (stall_cnt !== 16'd10) begin failures++; $display("FAIL cnt_10 got=%0d exp=10", stall_cnt); end
    checks++; if (c4_stall_cnt !== 4'd10) begin failures++; $display("FAIL cnt4_10 got=%0d exp=10", c4_stall_cnt); end
    repeat (10) tick();
    checks++; if (stall_cnt !== 16'd20) begin failures++; $display("FAIL cnt_20 got=%0d exp=20", stall_cnt); end
    checks++; if (c4_stall_cnt !== 4'd15) begin failures++; $display("FAIL cnt4_sat got=%0d exp=15", c4_stall_cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (stall_cnt !== 16'd0 || c4_stall_cnt !== 4'd0) begin failures++; $display("FAIL cnt_clr got=%0d/%0d exp=0/0", stall_cnt, c4_stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL cnt_resume got=%0d exp=1", stall_cnt); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (stall_cnt !== 16'd2 || out_valid !== 1'b0) begin failures++; $display("FAIL cnt_flush got c=%0d v=%0h exp c=2 v=0", stall_cnt, out_valid); end
    tick();
    checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL cnt_idle got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_skid0();
    checks++; if (s0_in_ready !== 1'b1 || s0_out_valid !== 1'b0) begin failures++; $display("FAIL s0_idle got r=%0h v=%0h exp r=1 v=0", s0_in_ready, s0_out_valid); end
    s0_out_ready = 1'b0; s0_in_valid = 1'b1; s0_in_data = 32'h11;
    tick();
    s0_in_valid = 1'b0;
    #1;
    checks++; if (s0_out_data !== 32'h11 || s0_in_ready !== 1'b0) begin failures++; $display("FAIL s0_full got d=%0h r=%0h exp d=11 r=0", s0_out_data, s0_in_ready); end
    s0_in_valid = 1'b1; s0_in_data = 32'h33;
    tick();
    checks++; if (s0_out_data !== 32'h11 || s0_out_valid !== 1'b1) begin failures++; $display("FAIL s0_no_skid got d=%0h v=%0h exp d=11 v=1", s0_out_data, s0_out_valid); end
    s0_in_valid = 1'b0;
    s0_out_ready = 1'b1;
    #1;
    checks++; if (s0_in_ready !== 1'b1) begin failures++; $display("FAIL s0_comb_ready got=%0h exp=1", s0_in_ready); end
    s0_in_valid = 1'b1; s0_in_data = 32'h22;
    tick();
    checks++; if (s0_out_valid !== 1'b1 || s0_out_data !== 32'h22) begin failures++; $display("FAIL s0_accept got v=%0h d=%0h exp v=1 d=22", s0_out_valid, s0_out_data); end
    s0_in_valid = 1'b0;
    tick();
    checks++; if (s0_out_valid !== 1'b0) begin failures++; $display("FAIL s0_drain got=%0h exp=0", s0_out_valid); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0; in_data = '0;
    s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0; s0_cnt_clr = 1'b0; s0_in_data = '0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_counter();
    test_skid0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
